// File: rtl/message_pkg.sv
// Shared definitions for the message printer and message RAM: FSM states, default sizes, line-ending bytes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package message_pkg;

  // Printer FSM states
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_WAIT_TX = 3'd2,
    S_SEND    = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  // Default sizes; MSG_LEN legal 1..16, RX_COUNT legal 1..15
  localparam int MSG_LEN_DEF  = 10;
  localparam int RX_COUNT_DEF = 8;

  // Line-ending bytes shared with message_ram contents
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  // Address of the last byte of a message of the given length
  function automatic logic [3:0] last_addr(input int len);
    return 4'(len - 1);
  endfunction

endpackage

// File: rtl/rx_byte_counter.sv
// Counts rising edges of the UART RX byte strobe and pulses threshold_o once every RX_COUNT edges.
// Latency: threshold_o rises the cycle after the edge that completes the count.
// Backpressure: none; every rising edge is counted, the counter wraps to 0 when the pulse fires.
module rx_byte_counter #(
  parameter int RX_COUNT = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic new_rx_data_i,
  output logic threshold_o
);

  localparam logic [3:0] CNT_LAST = 4'(RX_COUNT - 1);

  logic       rx_prev_q;
  logic [3:0] cnt_q, cnt_d;
  logic       thresh_q, thresh_d;
  logic       rx_rise;

  assign rx_rise = new_rx_data_i & ~rx_prev_q;

  // Next count: advance on each rising edge, clear and fire on reaching the threshold
  always_comb begin
    cnt_d    = cnt_q;
    thresh_d = 1'b0;
    if (rx_rise) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d    = 4'd0;
        thresh_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  // Edge-detect history, counter and registered threshold pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_prev_q <= 1'b0;
      cnt_q     <= 4'd0;
      thresh_q  <= 1'b0;
    end else begin
      rx_prev_q <= new_rx_data_i;
      cnt_q     <= cnt_d;
      thresh_q  <= thresh_d;
    end
  end

  assign threshold_o = thresh_q;

endmodule

// File: rtl/message_printer.sv
// Walks message RAM 0..MSG_LEN-1 and hands each byte to the UART TX; optional autostart via MSG_PRINTER_AUTOSTART_EN.
// Latency: first strobe 3 cycles after the trigger edge, then one byte every 3 cycles plus one per tx_busy cycle.
// Backpressure: holds in WAIT_TX while tx_busy_i is high; start_i while busy is dropped, autostart is remembered once.
module message_printer
  import message_pkg::*;
#(
  parameter int MSG_LEN  = MSG_LEN_DEF,
  parameter int RX_COUNT = RX_COUNT_DEF
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       new_rx_data_i,
  input  logic [7:0] ram_data_i,
  input  logic       tx_busy_i,
  output logic [3:0] addr_o,
  output logic [7:0] tx_data_o,
  output logic       new_tx_data_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam logic [3:0] LAST_ADDR = last_addr(MSG_LEN);

  state_e     state_q;
  logic [3:0] addr_q;
  logic [7:0] tx_data_q;
  logic       new_tx_q;
  logic       busy_q;
  logic       done_q;

  logic       thresh;   // autostart threshold pulse
  logic       rerun;    // start another message straight out of DONE

`ifdef MSG_PRINTER_AUTOSTART_EN
  logic pending_q;

  rx_byte_counter #(
    .RX_COUNT (RX_COUNT)
  ) u_rx_byte_counter (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .new_rx_data_i (new_rx_data_i),
    .threshold_o   (thresh)
  );

  // Remember a threshold hit while a message is in flight; consumed in DONE
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= 1'b0;
    end else if (state_q == S_DONE) begin
      pending_q <= 1'b0;
    end else if (thresh && busy_q) begin
      pending_q <= 1'b1;
    end
  end

  // A threshold landing in the DONE cycle itself also chains directly
  assign rerun = pending_q | thresh;
`else
  logic unused_rx;

  assign thresh    = 1'b0;
  assign rerun     = 1'b0;
  assign unused_rx = new_rx_data_i ^ (RX_COUNT == 0);
`endif

  // Print FSM with registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      addr_q    <= 4'd0;
      tx_data_q <= 8'd0;
      new_tx_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // start and threshold together still yield one message
          if (start_i || thresh) begin
            state_q <= S_FETCH;
            addr_q  <= 4'd0;
            busy_q  <= 1'b1;
          end
        end
        S_FETCH: begin
          // RAM registers ram_data_i for the current addr this cycle
          state_q <= S_WAIT_TX;
        end
        S_WAIT_TX: begin
          if (!tx_busy_i) begin
            tx_data_q <= ram_data_i;
            new_tx_q  <= 1'b1;
            state_q   <= S_SEND;
          end
        end
        S_SEND: begin
          new_tx_q <= 1'b0;
          if (addr_q == LAST_ADDR) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            addr_q  <= addr_q + 4'd1;
            state_q <= S_FETCH;
          end
        end
        S_DONE: begin
          done_q <= 1'b0;
          addr_q <= 4'd0;
          if (rerun) begin
            state_q <= S_FETCH;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          new_tx_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign addr_o        = addr_q;
  assign tx_data_o     = tx_data_q;
  assign new_tx_data_o = new_tx_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule

// File: doc/message_printer.md
# message_printer

Downstream consumer of `message_ram`. On a start event it walks the RAM address space from 0 to `MSG_LEN-1` and reads each byte. It hands each byte to the UART transmitter through the `new_tx_data`/`tx_busy` handshake. It sits between `message_ram` (addr out, data in) and `serial_tx`.

## Interface
- `MSG_LEN`, 10: bytes sent per message (RAM entries 0..MSG_LEN-1); legal range 1..16.
- `RX_COUNT`, 8: received bytes that trigger an automatic print (autostart build only); legal range 1..15.
- `clk`  input  1  system clock; all state changes on rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `start`  input  1  single-cycle request to print one message.
- `new_rx_data`  input  1  byte-received strobe from UART RX (autostart build only; ignored otherwise).
- `ram_data`  input  8  byte from `message_ram`; valid one cycle after `addr` changes.
- `tx_busy`  input  1  transmitter busy; rises the cycle after an accepted `new_tx_data`.
- `addr`  output  4  RAM read address.
- `tx_data`  output  8  byte to transmitter.
- `new_tx_data`  output  1  one-cycle strobe; transmitter takes `tx_data`.
- `busy`  output  1  high from start acceptance until `done`.
- `done`  output  1  one-cycle pulse after the last byte is handed off.

## Operation
- States: IDLE, FETCH, WAIT_TX, SEND, DONE.
- IDLE: `busy`=0. A trigger (`start`=1, or autostart threshold) moves to FETCH with `addr`=0.
- FETCH: one cycle for the RAM to register `ram_data`, then go to WAIT_TX.
- WAIT_TX: hold while `tx_busy`=1. When `tx_busy`=0, register `tx_data`<=`ram_data` and `new_tx_data`<=1, then go to SEND.
- SEND: `new_tx_data` is high for exactly this cycle and is cleared on exit.
  - If `addr`==`MSG_LEN-1`, go to DONE.
  - Otherwise `addr`<=`addr`+1 and go to FETCH.
- DONE: `done`=1 for one cycle; `addr`<=0; go to IDLE (or to FETCH if a print is pending).
- `addr` never exceeds `MSG_LEN-1`. No wrap occurs inside a message.
- A `start` while `busy`=1 is ignored. Print requests are not queued, except for the autostart pending flag.
- A `start` and the autostart threshold in the same cycle produce exactly one print.
- Reset mid-message: the message is abandoned immediately. There is no resume; the next print restarts at `addr`=0.

## Timing
- Reset values: `addr`=0, `tx_data`=0, `new_tx_data`=0, `busy`=0, `done`=0, state IDLE, RX counter=0, pending=0.
- All outputs are registered.
- With `tx_busy` held at 0:
  - start sampled at edge 0; FETCH in cycle 1; WAIT_TX in cycle 2; first `new_tx_data` in cycle 3.
  - After that, one byte every 3 cycles.
  - `done` appears in the cycle after the last SEND: cycle 3·MSG_LEN+1.
- Each cycle in which `tx_busy`=1 during WAIT_TX adds one cycle of latency.
- `busy` rises the cycle after the trigger and falls in the cycle after `done`.

## Configuration
- `MSG_PRINTER_AUTOSTART_EN` defined:
  - Rising edges of `new_rx_data` are counted.
  - When the count reaches `RX_COUNT`, the counter clears and a print is triggered.
  - If this happens while `busy`=1, a pending flag is set instead. The pending print starts from DONE, and the flag clears.
  - A `new_rx_data` edge in the same cycle as the counter clear counts as 1 toward the next threshold.
- Not defined: the counter and pending flag are absent, `new_rx_data` is unused, and only `start` triggers a print.

## Structure
- Shared package `message_pkg`: state encodings, default `MSG_LEN` and `RX_COUNT`, and the CR/LF byte constants shared with `message_ram`.
- One sub-module, `rx_byte_counter`: edge-detects `new_rx_data`, counts to `RX_COUNT` and emits a one-cycle `threshold` pulse. It is instantiated only when `MSG_PRINTER_AUTOSTART_EN` is defined.

## Test plan
- RAM model holds 0x30..0x39, `tx_busy`=0, `start` pulse at cycle 0 → `new_tx_data` in cycles 3,6,…,30 carrying 0x30..0x39 in order; `done` at cycle 31; `busy` high in cycles 1..31.
- Same stimulus, but `tx_busy` goes high for 5 cycles after each strobe → no strobe while `tx_busy`=1; 10 bytes in order; exactly one `done`.
- Second `start` at cycle 10 of a message → ignored; exactly 10 strobes; one `done`.
- `rst` driven low asynchronously mid-cycle at byte 4 → all outputs 0 at once; after release, `start` resends from 0x30.
- Autostart, `RX_COUNT`=8: 8 `new_rx_data` pulses → print begins; 8 more pulses during that print → second print begins straight from DONE with `addr`=0.
- Autostart build: threshold and `start` in the same cycle → exactly one message (10 strobes).
